flash_cache_arbiter: RTL

- Shares the single flash cache read port between N requesters, e.g. per-core instruction fetch and data read.
- Uses round-robin arbitration. A grant is held for one complete cache read.
- Captures the read data, returns it to the granted requester with a one-cycle acknowledge, and aborts stalled reads on a timeout.
- Sits between the core-side wishbone/fetch adapters and the flash cache read interface (readEnable/readAddress/readReady plus SRAM read data).

---
 rtl/flash_pkg.sv | 23 ++
 rtl/flash_cache_arbiter_picker.sv | 31 +++
 rtl/flash_cache_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared definitions for the flash cache and its read-port arbiter.
package flash_pkg;

  localparam int DEFAULT_ADDRESS_SIZE = 24;
  localparam int DEFAULT_DATA_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  // Ceiling log2 with a floor of 1 so that index signals are never zero width.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/flash_cache_arbiter_picker.sv
// Combinational round-robin picker: first requester after the last grant, wrapping.
module round_robin_picker
  import flash_pkg::*;
#(
  parameter int PORT_COUNT = 2
) (
  input  logic [PORT_COUNT-1:0]        request,
  input  logic [clog2(PORT_COUNT)-1:0] lastGrant,
  output logic [clog2(PORT_COUNT)-1:0] pickIndex,
  output logic                         anyRequest
);

  localparam int INDEX_WIDTH = clog2(PORT_COUNT);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(PORT_COUNT - 1);

  // Walk every port once starting after lastGrant; wrap on the highest real port, not a power of two.
  always_comb begin
    logic [INDEX_WIDTH-1:0] candidate;
    pickIndex  = '0;
    anyRequest = 1'b0;
    candidate  = lastGrant;
    for (int i = 0; i < PORT_COUNT; i++) begin
      candidate = (candidate == LAST_INDEX) ? '0 : candidate + INDEX_WIDTH'(1);
      if (!anyRequest && request[candidate]) begin
        pickIndex  = candidate;
        anyRequest = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flash_cache_arbiter.sv
// Shares the flash cache read port between requesters with round-robin grants,
// one complete read per grant, a one-cycle ack and a stall timeout.
module flash_cache_arbiter
  import flash_pkg::*;
#(
  parameter int PORT_COUNT   = 2,
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_SIZE = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORT_COUNT-1:0]              port_request,
  input  logic [PORT_COUNT*ADDRESS_SIZE-1:0] port_address,
  output logic [PORT_COUNT-1:0]              port_ack,
  output logic [PORT_COUNT-1:0]              port_error,
  output logic [DATA_WIDTH-1:0]              port_data,
  output logic                               cache_readEnable,
  output logic [ADDRESS_SIZE-1:0]            cache_readAddress,
  input  logic                               cache_readReady,
  input  logic [DATA_WIDTH-1:0]              cache_readData,
  output logic                               busy,
  output logic [clog2(PORT_COUNT)-1:0]       grantIndex
);

  localparam int INDEX_WIDTH = clog2(PORT_COUNT);
  localparam logic [INDEX_WIDTH-1:0] RESET_POINTER = INDEX_WIDTH'(PORT_COUNT - 1);

  arb_state_t              state;
  logic [INDEX_WIDTH-1:0]  lastGrant;
  logic [INDEX_WIDTH-1:0]  pickIndex;
  logic                    anyRequest;
  logic [TIMEOUT_SIZE-1:0] timeout_count;

  round_robin_picker #(
    .PORT_COUNT(PORT_COUNT)
  ) picker (
    .request   (port_request),
    .lastGrant (lastGrant),
    .pickIndex (pickIndex),
    .anyRequest(anyRequest)
  );

  // Arbitration FSM: grant in IDLE, hold the latched address through ACCESS, then ack, abort or time out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      lastGrant         <= RESET_POINTER;
      grantIndex        <= '0;
      timeout_count     <= '0;
      cache_readEnable  <= 1'b0;
      cache_readAddress <= '0;
      port_data         <= '0;
      port_ack          <= '0;
      port_error        <= '0;
      busy              <= 1'b0;
    end else begin
      port_ack   <= '0;
      port_error <= '0;
      case (state)
        IDLE: begin
          if (anyRequest) begin
            state             <= ACCESS;
            grantIndex        <= pickIndex;
            lastGrant         <= pickIndex;
            cache_readAddress <= port_address[int'(pickIndex)*ADDRESS_SIZE +: ADDRESS_SIZE];
            timeout_count     <= '0;
            cache_readEnable  <= 1'b1;
            busy              <= 1'b1;
          end
        end
        ACCESS: begin
          if (cache_readReady) begin
            port_data            <= cache_readData;
            port_ack[grantIndex] <= 1'b1;
            cache_readEnable     <= 1'b0;
            state                <= RESPOND;
          end else if (!port_request[grantIndex]) begin
            cache_readEnable <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
          end else if (&timeout_count) begin
            port_error[grantIndex] <= 1'b1;
            cache_readEnable       <= 1'b0;
            busy                   <= 1'b0;
            state                  <= IDLE;
          end else begin
            timeout_count <= timeout_count + TIMEOUT_SIZE'(1);
          end
        end
        RESPOND: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          cache_readEnable <= 1'b0;
          busy             <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule
